alu_nibble_sequencer: RTL and testbench

ALU_NIBBLE_SEQUENCER -- requirements
Module: alu_nibble_sequencer

---
 rtl/alu_nibble_sequencer.sv | 155 +++++++++++++++
 tb/tb_alu_nibble_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_nibble_sequencer.sv
// Runs a W-bit ALU operation as NIBBLES passes through an external 4-bit slice, LSB nibble first.
// Optional ALU_SEQ_PIPE_EN: accept the next request on the same edge that completes a response.
module alu_nibble_sequencer #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [2:0]             req_op,
    input  logic [4*NIBBLES-1:0]   req_a,
    input  logic [4*NIBBLES-1:0]   req_b,
    output logic [3:0]             alu_a,
    output logic [3:0]             alu_b,
    output logic [2:0]             alu_op,
    output logic                   alu_cin,
    input  logic [3:0]             alu_result,
    input  logic                   alu_cout,
    input  logic                   alu_overflow,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [4*NIBBLES-1:0]   rsp_result,
    output logic                   rsp_cout,
    output logic                   rsp_overflow,
    output logic                   rsp_zero,
    output logic                   rsp_err
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [2:0]      op_q, op_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, res_q, res_d;
    logic            carry_q, carry_d, cout_q, cout_d, ovf_q, ovf_d, err_q, err_d;
    logic            accept, legal, slt_set;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        accept  = req_valid & req_ready;
        legal   = (req_op == OP_AND) || (req_op == OP_OR) || (req_op == OP_ADD) ||
                  (req_op == OP_SUB) || (req_op == OP_SLT);
        slt_set = alu_result[3] ^ alu_overflow;
        case (state_q)
            S_RUN: begin
                for (int i = 0; i < NIBBLES; i++) begin
                    if (idx_q == IW'(i)) res_d[i*4 +: 4] = alu_result;
                end
                carry_d = alu_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LAST) begin
                    state_d = S_DONE;
                    idx_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    if (op_q == OP_ADD || op_q == OP_SUB) begin
                        cout_d = alu_cout;
                        ovf_d  = alu_overflow;
                    end else if (op_q == OP_SLT) begin
                        res_d = {{(W-1){1'b0}}, slt_set};
                    end
                end
            end
            S_DONE: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: ;
        endcase
        // Acceptance only happens from IDLE, or from a completing DONE when pipelined.
        if (accept) begin
            state_d = legal ? S_RUN : S_DONE;
            idx_d   = '0;
            op_d    = req_op;
            a_d     = req_a;
            b_d     = req_b;
            res_d   = '0;
            carry_d = 1'b0;
            cout_d  = 1'b0;
            ovf_d   = 1'b0;
            err_d   = ~legal;
        end
    end

    always_comb begin
        req_ready = (state_q == S_IDLE);
`ifdef ALU_SEQ_PIPE_EN
        req_ready = req_ready | ((state_q == S_DONE) & rsp_ready);
`endif
        alu_a   = 4'h0;
        alu_b   = 4'h0;
        alu_op  = 3'b000;
        alu_cin = 1'b0;
        if (state_q == S_RUN) begin
            for (int i = 0; i < NIBBLES; i++) begin
                if (idx_q == IW'(i)) begin
                    alu_a = a_q[i*4 +: 4];
                    alu_b = b_q[i*4 +: 4];
                end
            end
            alu_op  = (op_q == OP_SLT) ? OP_SUB : op_q;
            alu_cin = (idx_q == '0) ? op_q[2] : carry_q;
        end
        rsp_valid    = (state_q == S_DONE);
        rsp_result   = rsp_valid ? res_q : '0;
        rsp_cout     = rsp_valid & cout_q;
        rsp_overflow = rsp_valid & ovf_q;
        rsp_err      = rsp_valid & err_q;
        // An error response reports only rsp_err; its all-zero result is not a "zero" outcome.
        rsp_zero     = rsp_valid & ~err_q & (res_q == '0);
    end
endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Directed bench for alu_nibble_sequencer (NIBBLES = 4) with a behavioural 4-bit ALU slice.
module tb_alu_nibble_sequencer;
    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_ready;
    logic [2:0]   req_op;
    logic [W-1:0] req_a, req_b;
    logic [3:0]   alu_a, alu_b, alu_result;
    logic [2:0]   alu_op;
    logic         alu_cin, alu_cout, alu_overflow;
    logic         rsp_valid, rsp_ready;
    logic [W-1:0] rsp_result;
    logic         rsp_cout, rsp_overflow, rsp_zero, rsp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_nibble_sequencer #(.NIBBLES(N)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_cin(alu_cin),
        .alu_result(alu_result), .alu_cout(alu_cout), .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_cout(rsp_cout), .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
        .rsp_err(rsp_err)
    );

    // Slice model: SUB is a + ~b + cin with cin = 1 on the first nibble.
    logic [4:0] s;
    logic [3:0] nb;
    always_comb begin
        s = 5'd0;
        nb = ~alu_b;
        alu_result = 4'h0;
        alu_cout = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'b000: alu_result = alu_a & alu_b;
            3'b001: alu_result = alu_a | alu_b;
            3'b010: begin
                s = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_cin};
                alu_result = s[3:0];
                alu_cout = s[4];
                alu_overflow = (alu_a[3] == alu_b[3]) && (s[3] != alu_a[3]);
            end
            3'b110: begin
                s = {1'b0, alu_a} + {1'b0, nb} + {4'b0, alu_cin};
                alu_result = s[3:0];
                alu_cout = s[4];
                alu_overflow = (alu_a[3] != alu_b[3]) && (s[3] != alu_a[3]);
            end
            default: ;
        endcase
    end

    // Presents one request, then scrambles req_* so only the registered copy can be used.
    // lat = edges after the acceptance edge until rsp_valid is seen (0 = on the acceptance edge).
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat);
        @(negedge clk);
        req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; req_a = 16'hDEAD; req_b = 16'hBEEF; req_op = 3'b001;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_rsp();
        @(negedge clk); rsp_ready = 1'b1;
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        checks++; if (rsp_valid !== 1'b0 || rsp_result !== 16'h0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL reset_rsp got v=%b r=%h z=%b e=%b want 0", rsp_valid, rsp_result, rsp_zero, rsp_err); end
        checks++; if (alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'b000 || alu_cin !== 1'b0) begin
            errors++; $display("FAIL reset_alu got a=%h b=%h op=%b cin=%b want 0", alu_a, alu_b, alu_op, alu_cin); end
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", req_ready); end
    endtask

    task automatic test_add();
        int lat;
        run_op(3'b010, 16'h00FF, 16'h0001, lat);
        checks++; if (lat !== 4) begin errors++; $display("FAIL add_latency got %0d want 4", lat); end
        checks++; if (rsp_result !== 16'h0100) begin errors++; $display("FAIL add_result got %h want 0100", rsp_result); end
        checks++; if ({rsp_cout, rsp_overflow, rsp_zero, rsp_err} !== 4'b0000) begin
            errors++; $display("FAIL add_flags got c/o/z/e=%b want 0000", {rsp_cout, rsp_overflow, rsp_zero, rsp_err}); end
        release_rsp();
    endtask

    task automatic test_sub();
        int lat;
        run_op(3'b110, 16'h8000, 16'h0001, lat);
        checks++; if (rsp_result !== 16'h7FFF) begin errors++; $display("FAIL sub1_result got %h want 7fff", rsp_result); end
        checks++; if ({rsp_cout, rsp_overflow, rsp_zero} !== 3'b110) begin
            errors++; $display("FAIL sub1_flags got c/o/z=%b want 110", {rsp_cout, rsp_overflow, rsp_zero}); end
        // Stall: response must hold and no new request is taken.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); req_valid = 1'b1; req_op = 3'b010;
            #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_result !== 16'h7FFF || req_ready !== 1'b0) begin
                errors++; $display("FAIL stall_hold got v=%b r=%h rdy=%b want 1 7fff 0", rsp_valid, rsp_result, req_ready); end
        end
        req_valid = 1'b0;
        release_rsp();
        run_op(3'b110, 16'h1234, 16'h1234, lat);
        checks++; if (rsp_result !== 16'h0000) begin errors++; $display("FAIL sub2_result got %h want 0000", rsp_result); end
        checks++; if ({rsp_cout, rsp_overflow, rsp_zero} !== 3'b101) begin
            errors++; $display("FAIL sub2_flags got c/o/z=%b want 101", {rsp_cout, rsp_overflow, rsp_zero}); end
        release_rsp();
    endtask

    task automatic test_slt();
        int lat;
        run_op(3'b111, 16'hFFFF, 16'h0001, lat);
        checks++; if (rsp_result !== 16'h0001 || rsp_zero !== 1'b0) begin
            errors++; $display("FAIL slt1 got r=%h z=%b want 0001 0", rsp_result, rsp_zero); end
        release_rsp();
        run_op(3'b111, 16'h0005, 16'h0003, lat);
        checks++; if (rsp_result !== 16'h0000 || {rsp_zero, rsp_cout, rsp_overflow} !== 3'b100) begin
            errors++; $display("FAIL slt2 got r=%h z/c/o=%b want 0000 100", rsp_result, {rsp_zero, rsp_cout, rsp_overflow}); end
        release_rsp();
    endtask

    task automatic test_logic();
        int lat;
        run_op(3'b000, 16'hF0F0, 16'h0F0F, lat);
        checks++; if (rsp_result !== 16'h0000 || {rsp_zero, rsp_cout, rsp_overflow} !== 3'b100) begin
            errors++; $display("FAIL and got r=%h z/c/o=%b want 0000 100", rsp_result, {rsp_zero, rsp_cout, rsp_overflow}); end
        release_rsp();
        run_op(3'b001, 16'h1200, 16'h0034, lat);
        checks++; if (rsp_result !== 16'h1234 || {rsp_zero, rsp_cout, rsp_overflow} !== 3'b000) begin
            errors++; $display("FAIL or got r=%h z/c/o=%b want 1234 000", rsp_result, {rsp_zero, rsp_cout, rsp_overflow}); end
        release_rsp();
    endtask

    task automatic test_illegal();
        int lat;
        run_op(3'b011, 16'h1111, 16'h2222, lat);
        // Illegal ops complete on the acceptance edge itself.
        checks++; if (lat !== 0) begin errors++; $display("FAIL illegal_latency got %0d want 0", lat); end
        checks++; if (rsp_err !== 1'b1 || rsp_result !== 16'h0 || {rsp_cout, rsp_overflow, rsp_zero} !== 3'b000) begin
            errors++; $display("FAIL illegal_rsp got e=%b r=%h c/o/z=%b want 1 0000 000", rsp_err, rsp_result, {rsp_cout, rsp_overflow, rsp_zero}); end
        release_rsp();
    endtask

    task automatic test_reset_mid();
        logic seen;
        @(negedge clk);
        req_op = 3'b010; req_a = 16'h0A00; req_b = 16'h0500; req_valid = 1'b1;
        @(posedge clk); #1; req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checks++; if (alu_a !== 4'hA || alu_b !== 4'h5 || alu_op !== 3'b010) begin
            errors++; $display("FAIL mid_nibble2 got a=%h b=%h op=%b want a 5 010", alu_a, alu_b, alu_op); end
        reset = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || alu_a !== 4'h0 || alu_b !== 4'h0 || alu_op !== 3'b000 || alu_cin !== 1'b0) begin
            errors++; $display("FAIL mid_reset got v=%b a=%h b=%h op=%b cin=%b want 0", rsp_valid, alu_a, alu_b, alu_op, alu_cin); end
        @(negedge clk); reset = 1'b0;
        #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", req_ready); end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (rsp_valid === 1'b1) seen = 1'b1; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL mid_no_rsp got rsp_valid seen=%b want 0", seen); end
    endtask

    // Gap = edges from the edge that consumes the first response to the second rsp_valid.
    task automatic test_back_to_back();
        int lat, gap, want;
`ifdef ALU_SEQ_PIPE_EN
        want = 4;
`else
        want = 5;
`endif
        @(negedge clk);
        rsp_ready = 1'b1; req_valid = 1'b1; req_op = 3'b010; req_a = 16'h0001; req_b = 16'h0001;
        @(posedge clk); #1;
        req_a = 16'h0003; req_b = 16'h0004;
        lat = 0;
        while (rsp_valid !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
        checks++; if (lat !== 4 || rsp_result !== 16'h0002) begin
            errors++; $display("FAIL b2b_first got lat=%0d r=%h want 4 0002", lat, rsp_result); end
        @(posedge clk); #1;
        gap = 0;
        while (rsp_valid !== 1'b1 && gap < 20) begin @(posedge clk); #1; gap++; end
        req_valid = 1'b0;
        checks++; if (gap !== want) begin errors++; $display("FAIL b2b_gap got %0d want %0d", gap, want); end
        checks++; if (rsp_result !== 16'h0007) begin errors++; $display("FAIL b2b_second got %h want 0007", rsp_result); end
        @(posedge clk); #1; rsp_ready = 1'b0;
    endtask

    initial begin
        req_valid = 1'b0; req_op = 3'b000; req_a = '0; req_b = '0; rsp_ready = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
